// File: rtl/gpu_pkg.sv
// Shared GPU core parameters and the fetch bundle carried across IF/ID into decode.
package gpu_pkg;
  localparam int NTHREADS = 4;
  localparam int TID_W    = 2;
  localparam int PC_W     = 9;
  localparam int INSTR_W  = 32;

  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [TID_W-1:0]   tid;
    logic [INSTR_W-1:0] instr;
  } fetch_bundle_t;
endpackage

// File: rtl/gpu_fetch_stage_rr_arbiter.sv
// Combinational round-robin arbiter: first request found searching from last_tid+1.
module rr_arbiter
  import gpu_pkg::*;
#(
  parameter int N  = NTHREADS,
  parameter int TW = TID_W
) (
  input  logic [N-1:0]  req,
  input  logic [TW-1:0] last_tid,
  output logic          grant_valid,
  output logic [N-1:0]  grant,
  output logic [TW-1:0] grant_tid
);

  logic [TW-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_tid   = last_tid;
    grant       = '0;
    idx         = '0;
    // Offset N wraps back onto last_tid itself, so it is searched last.
    for (int i = 1; i <= N; i++) begin
      idx = last_tid + TW'(i);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_tid   = idx;
      end
    end
    if (grant_valid) grant[grant_tid] = 1'b1;
  end

endmodule

// File: rtl/gpu_fetch_stage.sv
// Multithreaded instruction fetch: round-robin thread pick, synchronous imem read,
// one-stage F1 tracking of the in-flight fetch with stall hold and redirect squash.
module gpu_fetch_stage
  import gpu_pkg::*;
#(
  parameter int NTHREADS = gpu_pkg::NTHREADS,
  parameter int TID_W    = gpu_pkg::TID_W,
  parameter int PC_W     = gpu_pkg::PC_W,
  parameter int INSTR_W  = gpu_pkg::INSTR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_i,
  input  logic [NTHREADS-1:0] thread_en,
  input  logic                redirect_valid,
  input  logic [TID_W-1:0]    redirect_tid,
  input  logic [PC_W-1:0]     redirect_pc,
  output logic                imem_rd_en,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                out_valid,
  output logic [INSTR_W-1:0]  out_instr,
  output logic [PC_W-1:0]     out_pc,
  output logic [TID_W-1:0]    out_tid,
  output logic                if_id_en
);

  logic [NTHREADS-1:0][PC_W-1:0] pc_all;
  logic [TID_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic                          f1_valid_q, f1_valid_d;
  logic [PC_W-1:0]               f1_pc_q, f1_pc_d;
  logic [TID_W-1:0]              f1_tid_q, f1_tid_d;

  logic                sel_valid;
  logic [NTHREADS-1:0] sel_onehot;
  logic [TID_W-1:0]    sel_tid;
  logic                issue;
  logic [PC_W-1:0]     sel_pc;

  rr_arbiter #(
    .N  (NTHREADS),
    .TW (TID_W)
  ) u_arb (
    .req         (thread_en),
    .last_tid    (rr_ptr_q),
    .grant_valid (sel_valid),
    .grant       (sel_onehot),
    .grant_tid   (sel_tid)
  );

  assign issue = ~stall_i & ~rst & sel_valid;

  always_comb begin
    sel_pc = '0;
    for (int i = 0; i < NTHREADS; i++) begin
      sel_pc = sel_pc | (pc_all[i] & {PC_W{sel_onehot[i]}});
    end
  end

  // Per-thread PC: redirect outranks the post-issue increment.
  for (genvar gi = 0; gi < NTHREADS; gi++) begin : g_pc
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
      pc_d = pc_q;
      if (redirect_valid && redirect_tid == TID_W'(gi)) begin
        pc_d = redirect_pc;
      end else if (issue && sel_onehot[gi]) begin
        pc_d = pc_q + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) pc_q <= '0;
      else     pc_q <= pc_d;
    end

    assign pc_all[gi] = pc_q;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    f1_valid_d = f1_valid_q;
    f1_pc_d    = f1_pc_q;
    f1_tid_d   = f1_tid_q;
    if (issue) begin
      rr_ptr_d   = sel_tid;
      f1_valid_d = ~(redirect_valid && redirect_tid == sel_tid);
      f1_pc_d    = sel_pc;
      f1_tid_d   = sel_tid;
    end else if (!stall_i) begin
      f1_valid_d = 1'b0;
    end else if (redirect_valid && f1_tid_q == redirect_tid) begin
      f1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= TID_W'(NTHREADS - 1);
      f1_valid_q <= 1'b0;
      f1_pc_q    <= '0;
      f1_tid_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      f1_valid_q <= f1_valid_d;
      f1_pc_q    <= f1_pc_d;
      f1_tid_q   <= f1_tid_d;
    end
  end

  assign imem_rd_en = issue;
  assign imem_addr  = issue ? sel_pc : '0;
  assign out_valid  = f1_valid_q;
  assign out_pc     = f1_pc_q;
  assign out_tid    = f1_tid_q;
  assign out_instr  = imem_rdata;
  assign if_id_en   = ~stall_i;

endmodule

// File: doc/gpu_fetch_stage.md
# gpu_fetch_stage

Instruction fetch stage of the GPU core pipeline, directly upstream of the IF/ID pipeline register. Holds one program counter per hardware thread, picks a thread round-robin each cycle, issues a synchronous read to instruction memory and presents the returned instruction with its PC and thread ID as the IF/ID register's D bundle. Supports downstream stall and per-thread branch redirect with squash of in-flight fetches.

## Interface
- NTHREADS, 4: hardware threads; power of two, 2..8
- TID_W, 2: thread ID width, log2(NTHREADS)
- PC_W, 9: word-address PC width
- INSTR_W, 32: instruction width

Ports:
- clk  in  1  pipeline clock; everything is sampled on its rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  downstream cannot accept; hold all fetch state
- thread_en  in  NTHREADS  per-thread fetch enable mask
- redirect_valid  in  1  branch/jump resolved; load a new PC
- redirect_tid  in  TID_W  thread being redirected
- redirect_pc  in  PC_W  new PC for redirect_tid
- imem_rd_en  out  1  instruction memory read enable
- imem_addr  out  PC_W  instruction memory word address
- imem_rdata  in  INSTR_W  read data, valid one cycle after an enabled read; held by memory while imem_rd_en=0
- out_valid  out  1  out_* carries a live instruction
- out_instr  out  INSTR_W  instruction; equals imem_rdata
- out_pc  out  PC_W  PC of out_instr
- out_tid  out  TID_W  thread of out_instr
- if_id_en  out  1  enable for the downstream IF/ID register; equals ~stall_i

## Operation
- State: pc[NTHREADS], rr_ptr (last issued tid), F1 registers f1_valid/f1_pc/f1_tid; out_valid/out_pc/out_tid are the F1 registers.
- Reset: all pc = 0; rr_ptr = NTHREADS-1, so thread 0 issues first; f1_valid = 0, f1_pc = 0, f1_tid = 0; imem_rd_en = 0, imem_addr = 0. out_instr is not reset and is qualified only by out_valid.
- Selection (comb): sel = first tid with thread_en set, searching cyclically from rr_ptr+1. issue = ~stall_i & ~rst & |thread_en.
- On issue:
  - imem_rd_en = 1, imem_addr = pc[sel].
  - Next cycle: f1_valid <= 1, f1_pc <= pc[sel], f1_tid <= sel.
  - pc[sel] <= pc[sel]+1, wrapping modulo 2^PC_W.
  - rr_ptr <= sel.
- No enabled thread and not stalled: imem_rd_en = 0; f1_valid <= 0.
- Stall: imem_rd_en = 0. pc, rr_ptr and F1 hold. The memory holds imem_rdata, so the out_* bundle is stable.
- Redirect, which applies even while stalled:
  - pc[redirect_tid] <= redirect_pc; this takes priority over the increment when sel == redirect_tid in the same cycle.
  - Squash: if f1_valid and f1_tid == redirect_tid, f1_valid <= 0. This applies whether or not the stage is stalled.
  - If an issue in the same cycle has sel == redirect_tid, the fetch is sent to memory but f1_valid <= 0.
- thread_en change: takes effect at the next selection. An already-issued fetch still completes.

## Timing
- Fetch latency: 1 cycle from issue (imem_rd_en=1 at cycle t) to out_valid at t+1.
- Throughput: one instruction per cycle when unstalled. With k enabled threads, each thread issues every k cycles.
- Redirect at cycle t: the first fetch from the new PC can issue at t+1. Stale instructions of that thread are never presented after t.
- stall_i is combinational to imem_rd_en and if_id_en (zero-cycle response).

## Structure
- Shared package gpu_pkg carries NTHREADS, TID_W, PC_W, INSTR_W and the fetch bundle typedef {valid, pc, tid, instr}, which IF/ID and decode also use.
- Sub-module rr_arbiter (NTHREADS requests, last-grant pointer in, one-hot/tid grant out) is combinational and reused by the scheduler. Target size is roughly 150-250 lines total.

## Test plan
- Reset then thread_en=4'b1111, no stall, memory returns addr-tagged data: out_tid sequence 0,1,2,3,0… and out_pc 0,0,0,0,1,1… starting one cycle after reset release.
- thread_en=4'b0101: issue alternates tid 0 and 2 only. Set thread_en=0: imem_rd_en=0 and out_valid=0 the next cycle.
- stall_i high for 3 cycles mid-stream: imem_rd_en=0, if_id_en=0, and out_valid/out_pc/out_tid/out_instr are unchanged for all 3 cycles. After release the sequence resumes with no skip or duplicate.
- Squash in F1: redirect tid 1 to 0x100 while F1 holds tid 1. out_valid=0 next cycle, and tid 1's next presented out_pc = 0x100.
- Redirect during issue and stall: redirect in the same cycle sel==1 → no stale tid-1 instruction is presented. Redirect while stalled with F1 tid==redirect_tid → out_valid drops while still stalled.
- PC wrap: pc[0] = 0x1FF issues and is followed by 0x000. Reset asserted mid-stream → out_valid=0 and all PCs 0 the next cycle.
